// File: rtl/fft_reorder_buffer_if.sv
// Streaming sample bus for the FFT reorder buffer: input samples in,
// reordered samples plus frame markers and resync flag out.
interface fft_reorder_buffer_if #(
  parameter int DATA_W = 16
) ();
  logic                     in_valid;
  logic                     in_sof;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic                     out_sof;
  logic                     out_eof;
  logic                     sync_err;

  // Sample source / sink side.
  modport master (
    output in_valid, in_sof, in_re, in_im,
    input  out_valid, out_re, out_im, out_sof, out_eof, sync_err
  );

  // Reorder buffer side.
  modport slave (
    input  in_valid, in_sof, in_re, in_im,
    output out_valid, out_re, out_im, out_sof, out_eof, sync_err
  );
endinterface

// File: rtl/fft_reorder_buffer.sv
// Ping-pong frame buffer that reorders FFT_N-sample frames into bit-reversed
// (BITREV=1) or natural (BITREV=0) index order. One bank fills while the
// other is read out over FFT_N consecutive cycles.
module fft_reorder_buffer #(
  parameter int FFT_N  = 1024,
  parameter int DATA_W = 16,
  parameter bit BITREV = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_reorder_buffer_if.slave  bus
);

  localparam int AW = $clog2(FFT_N);
  localparam int WW = 2 * DATA_W;

  typedef enum logic {
    RD_IDLE,
    RD_BUSY
  } rd_state_e;

  // Both banks live in one array; the top address bit selects the bank.
  logic [WW-1:0] mem_q [2*FFT_N];

  logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    full_q,    full_d;
  logic [AW-1:0] rd_cnt_q,  rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  rd_state_e     rd_state_q, rd_state_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_re;
  logic [AW-1:0] rd_addr;
  logic          sync_d;

  logic [WW-1:0] rd_data_q;
  logic          out_valid_q;
  logic          out_sof_q;
  logic          out_eof_q;
  logic          sync_err_q;

  // Read address: read counter, optionally with its bits reversed.
  always_comb begin
    rd_addr = rd_cnt_q;
    if (BITREV) begin
      for (int unsigned i = 0; i < AW; i++) begin
        rd_addr[i] = rd_cnt_q[AW-1-i];
      end
    end
  end

  // Next-state logic for the write counter, bank flags and read FSM.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    full_d     = full_q;
    wr_en      = 1'b0;
    wr_addr    = wr_cnt_q;
    sync_d     = 1'b0;
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    rd_re      = 1'b0;

    // Read side is evaluated first so a bank release never masks a
    // simultaneous hand-over of the other bank.
    unique case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = RD_BUSY;
          rd_cnt_d   = '0;
        end
      end
      RD_BUSY: begin
        rd_re    = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (&rd_cnt_q) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          // Continue straight into the other bank if it is already waiting.
          if (!full_q[~rd_bank_q]) begin
            rd_state_d = RD_IDLE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    if (bus.in_valid) begin
      wr_en = 1'b1;
      if (bus.in_sof && (wr_cnt_q != '0)) begin
        // Early start-of-frame: drop the partial frame and restart at index 0.
        wr_addr  = '0;
        wr_cnt_d = AW'(1);
        sync_d   = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (&wr_cnt_q) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_state_q <= RD_IDLE;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank_q, wr_addr}] <= {bus.in_re, bus.in_im};
    end
  end

  // Registered read port; cleared whenever no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_re) begin
      rd_data_q <= mem_q[{rd_bank_q, rd_addr}];
    end else begin
      rd_data_q <= '0;
    end
  end

  // Registered output qualifiers and resync pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      out_valid_q <= rd_re;
      out_sof_q   <= rd_re && (rd_cnt_q == '0);
      out_eof_q   <= rd_re && (&rd_cnt_q);
      sync_err_q  <= sync_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = rd_data_q[WW-1:DATA_W];
  assign bus.out_im    = rd_data_q[DATA_W-1:0];
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Directed bench for fft_reorder_buffer with FFT_N=8: one bit-reversing
// instance and one natural-order instance fed from the same stimulus.
module tb_fft_reorder_buffer;

  localparam int DW = 16;

  typedef struct {
    bit v;
    bit sof;
    int re;
    int im;
    bit ev;
    int ere;
    int eim;
    bit esof;
    bit eeof;
  } vec_t;

  typedef struct {
    int stamp;
    int re;
    int im;
    bit sof;
    bit eof;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                 s_valid = 1'b0;
  logic                 s_sof   = 1'b0;
  logic signed [DW-1:0] s_re    = '0;
  logic signed [DW-1:0] s_im    = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sync_cnt   = 0;
  int sync_stamp = -1;
  int zero_viol  = 0;

  smp_t qr[$];
  smp_t qn[$];

  int   rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  vec_t tbl [18];

  fft_reorder_buffer_if #(.DATA_W(DW)) if_r ();
  fft_reorder_buffer_if #(.DATA_W(DW)) if_n ();

  assign if_r.in_valid = s_valid;
  assign if_r.in_sof   = s_sof;
  assign if_r.in_re    = s_re;
  assign if_r.in_im    = s_im;
  assign if_n.in_valid = s_valid;
  assign if_n.in_sof   = s_sof;
  assign if_n.in_re    = s_re;
  assign if_n.in_im    = s_im;

  fft_reorder_buffer #(.FFT_N(8), .DATA_W(DW), .BITREV(1'b1)) u_rev (
    .clk (clk),
    .rst (rst),
    .bus (if_r.slave)
  );

  fft_reorder_buffer #(.FFT_N(8), .DATA_W(DW), .BITREV(1'b0)) u_nat (
    .clk (clk),
    .rst (rst),
    .bus (if_n.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (if_r.out_valid === 1'b1)
      qr.push_back('{cyc, int'(if_r.out_re), int'(if_r.out_im), if_r.out_sof, if_r.out_eof});
    if (if_n.out_valid === 1'b1)
      qn.push_back('{cyc, int'(if_n.out_re), int'(if_n.out_im), if_n.out_sof, if_n.out_eof});
    if (if_r.sync_err === 1'b1) begin
      sync_cnt++;
      sync_stamp = cyc;
    end
    if (if_r.out_valid === 1'b0 &&
        (if_r.out_re !== '0 || if_r.out_im !== '0 || if_r.out_sof !== 1'b0 || if_r.out_eof !== 1'b0))
      zero_viol++;
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input bit v, input bit sof, input int re, input int im, output int at);
    s_valid = v;
    s_sof   = sof;
    s_re    = DW'(re);
    s_im    = DW'(im);
    tick();
    at      = cyc;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic clear_logs();
    qr.delete();
    qn.delete();
    sync_cnt   = 0;
    sync_stamp = -1;
  endtask

  // Sends one frame re=base+i, im=-(base+i); returns the capture cycle of its last sample.
  task automatic send_frame(input int base, output int last);
    int t;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, i == 0, base + i, -(base + i), t);
    end
    last = t;
  endtask

  // Checks 8 logged samples starting at idx0 against one expected output frame.
  task automatic check_frame(input bit nat, input int idx0, input int base, input int stamp0, input string tag);
    smp_t s;
    int   e;
    for (int j = 0; j < 8; j++) begin
      if (nat ? (idx0 + j < qn.size()) : (idx0 + j < qr.size())) begin
        s = nat ? qn[idx0 + j] : qr[idx0 + j];
        e = base + (nat ? j : rev_tab[j]);
        chk($sformatf("%s[%0d] cycle", tag, j), s.stamp, stamp0 + j);
        chk($sformatf("%s[%0d] re", tag, j), s.re, e);
        chk($sformatf("%s[%0d] im", tag, j), s.im, -e);
        chk($sformatf("%s[%0d] sof", tag, j), s.sof, j == 0);
        chk($sformatf("%s[%0d] eof", tag, j), s.eof, j == 7);
      end
    end
  endtask

  initial begin
    int t, t4, last, l1;

    // Single frame re=i, im=-i: out_valid rises two edges after the last capture.
    for (int i = 0; i < 18; i++) begin
      tbl[i] = '{default: 0};
      if (i < 8) begin
        tbl[i].v   = 1'b1;
        tbl[i].sof = (i == 0);
        tbl[i].re  = i;
        tbl[i].im  = -i;
      end
      if (i >= 9 && i < 17) begin
        tbl[i].ev   = 1'b1;
        tbl[i].ere  = rev_tab[i-9];
        tbl[i].eim  = -rev_tab[i-9];
        tbl[i].esof = (i == 9);
        tbl[i].eeof = (i == 16);
      end
    end

    // Reset state.
    rst = 1'b1;
    idle(2);
    chk("reset out_valid", if_r.out_valid, 0);
    chk("reset out_re", if_r.out_re, 0);
    chk("reset out_im", if_r.out_im, 0);
    chk("reset out_sof", if_r.out_sof, 0);
    chk("reset out_eof", if_r.out_eof, 0);
    chk("reset sync_err", if_r.sync_err, 0);
    rst = 1'b0;
    clear_logs();

    // Table-driven single frame.
    for (int i = 0; i < 18; i++) begin
      s_valid = tbl[i].v;
      s_sof   = tbl[i].sof;
      s_re    = DW'(tbl[i].re);
      s_im    = DW'(tbl[i].im);
      tick();
      chk($sformatf("vec%0d out_valid", i), if_r.out_valid, tbl[i].ev);
      chk($sformatf("vec%0d out_re", i), if_r.out_re, tbl[i].ere);
      chk($sformatf("vec%0d out_im", i), if_r.out_im, tbl[i].eim);
      chk($sformatf("vec%0d out_sof", i), if_r.out_sof, tbl[i].esof);
      chk($sformatf("vec%0d out_eof", i), if_r.out_eof, tbl[i].eeof);
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;

    // Back-to-back frames: 16 gapless outputs.
    clear_logs();
    send_frame(0, l1);
    send_frame(8, last);
    idle(25);
    chk("b2b count", qr.size(), 16);
    check_frame(1'b0, 0, 0, l1 + 2, "b2b f0");
    check_frame(1'b0, 8, 8, l1 + 10, "b2b f1");

    // Toggling in_valid; in_sof on idle cycles must be ignored.
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, i == 0, i, -i, t);
      last = t;
      send(1'b0, 1'b1, 99, 99, t);
    end
    idle(20);
    chk("toggle count", qr.size(), 8);
    check_frame(1'b0, 0, 0, last + 2, "toggle");
    chk("toggle sync_err count", sync_cnt, 0);

    // Resync after 3 samples: partial frame discarded.
    clear_logs();
    for (int i = 0; i < 3; i++) send(1'b1, i == 0, 100 + i, -(100 + i), t);
    send(1'b1, 1'b1, 0, 0, t4);
    for (int i = 1; i < 8; i++) begin
      send(1'b1, 1'b0, i, -i, t);
      last = t;
    end
    idle(20);
    chk("resync sync_err count", sync_cnt, 1);
    chk("resync sync_err cycle", sync_stamp, t4);
    chk("resync count", qr.size(), 8);
    check_frame(1'b0, 0, 0, last + 2, "resync");

    // Reset during the 4th output sample.
    clear_logs();
    send_frame(0, last);
    idle(5);
    rst = 1'b1;
    tick();
    chk("abort out_valid", if_r.out_valid, 0);
    chk("abort out_re", if_r.out_re, 0);
    chk("abort out_sof", if_r.out_sof, 0);
    chk("abort out_eof", if_r.out_eof, 0);
    rst = 1'b0;
    chk("abort samples before reset", qr.size(), 4);
    clear_logs();
    idle(15);
    chk("abort stale samples", qr.size(), 0);
    send_frame(0, last);
    idle(20);
    chk("post-abort count", qr.size(), 8);
    check_frame(1'b0, 0, 0, last + 2, "post-abort");

    // Natural-order instance.
    clear_logs();
    send_frame(0, last);
    idle(20);
    chk("natural count", qn.size(), 8);
    check_frame(1'b1, 0, 0, last + 2, "natural");

    chk("idle outputs nonzero count", zero_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_reorder_buffer.md
FFT_REORDER_BUFFER -- requirements
Module: fft_reorder_buffer

Interface
REQ-001 Parameter FFT_N, default 1024, frame length in samples; SHALL be a power of two, at least 4.
REQ-002 Parameter DATA_W, default 16, signed width of each real and imaginary component.
REQ-003 Parameter BITREV, default 1; 1 = read out in bit-reversed index order, 0 = natural order (frame-aligned delay).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_re/in_im carry a sample this cycle.
REQ-007 in_sof  input  1  qualified by in_valid; marks sample index 0 of a frame.
REQ-008 in_re, in_im  input  DATA_W each  signed sample components.
REQ-009 out_valid  output  1  out_re/out_im carry a sample this cycle.
REQ-010 out_re, out_im  output  DATA_W each  signed reordered sample components.
REQ-011 out_sof, out_eof  output  1 each  first and last sample of an output frame, qualified by out_valid.
REQ-012 sync_err  output  1  one-cycle pulse on frame resynchronisation.

Function
REQ-013 Two banks (ping-pong), FFT_N x 2*DATA_W each; write address width and read address width SHALL be clog2(FFT_N).
REQ-014 Write side: each in_valid cycle stores the sample at wr_cnt in the write bank, then increments wr_cnt.
REQ-015 The write bank SHALL be full when wr_cnt wraps from FFT_N-1 to 0.
REQ-016 When the write bank becomes full, it is handed to the read side, and the write side switches to the other bank in the same edge.
REQ-017 No in_valid cycles are lost at a bank switch.
REQ-018 in_valid with in_sof while wr_cnt != 0 SHALL discard the partial frame.
REQ-019 In that case the sample SHALL be stored at index 0, wr_cnt SHALL become 1, and sync_err SHALL pulse high for one cycle.
REQ-020 in_sof with wr_cnt == 0 is normal and does not pulse sync_err.
REQ-021 in_sof without in_valid SHALL be ignored.
REQ-022 Read side: a handed-over bank SHALL be read over exactly FFT_N consecutive cycles, one address per cycle, independent of in_valid.
REQ-023 The read address is rd_cnt when BITREV=0, or rd_cnt with its clog2(FFT_N) bits reversed when BITREV=1.
REQ-024 Latency: the first output sample of a frame SHALL be valid in the cycle after the 2nd rising edge following the edge that captured that frame's last input sample.
REQ-025 Output data SHALL be registered.
REQ-026 out_sof SHALL be high with the rd_cnt==0 sample, and out_eof SHALL be high with the rd_cnt==FFT_N-1 sample.
REQ-027 Back-to-back frames SHALL produce a gapless out_valid run: the next bank's read starts the cycle after the previous read ends.
REQ-028 Read side: a full bank waiting while a read is in progress SHALL start immediately after that read.
REQ-029 Because input rate is at most one sample per cycle, no overflow path exists.
REQ-030 Any design state that would permit overwrite of an unread bank SHALL be unreachable.
REQ-031 When out_valid is low, out_re, out_im, out_sof and out_eof SHALL hold 0.
REQ-032 Samples SHALL pass bit-exact: no arithmetic, scaling or sign change.
REQ-033 Storage SHALL be inferable as simple dual-port RAM: one write port and one registered read port.

Reset
REQ-034 During rst: wr_cnt=0, rd_cnt=0, both banks marked empty, write bank=0, read side idle.
REQ-035 During rst, all outputs SHALL be 0.
REQ-036 rst SHALL take priority over in_valid in the same cycle.
REQ-037 rst asserted mid-frame or mid-read SHALL abort both sides.
REQ-038 After that abort, out_valid SHALL be 0 in the cycle after the reset edge, and no stale sample SHALL be emitted afterwards.
REQ-039 RAM contents need no reset; bank-full flags alone gate reads.

Verification
REQ-040 FFT_N=8, BITREV=1, 8 contiguous samples re=i, im=-i -> after the REQ-024 latency, 8 contiguous out_valid cycles.
REQ-041 In that run, out_re = 0,4,2,6,1,5,3,7 and out_im the negation, with out_sof on the first sample and out_eof on the last.
REQ-042 FFT_N=8, two back-to-back frames (second re=8+i) -> 16 contiguous out_valid cycles, with out_sof at output cycles 0 and 8 and out_eof at 7 and 15.
REQ-043 FFT_N=8, in_valid toggling 1,0,1,0 across a frame -> the output frame is identical to REQ-041 and starts 2 edges after the 8th accepted sample.
REQ-044 FFT_N=8, 3 samples then in_sof with a new sample -> sync_err pulses once, and the first 3 samples never appear at the output.
REQ-045 FFT_N=8, rst asserted during the 4th output sample -> out_valid is 0 from the next cycle, and a new 8-sample frame then reproduces REQ-041.
REQ-046 FFT_N=8, BITREV=0, samples re=i -> out_re = 0..7 in natural order.
